// File: rtl/regbank_arb_if.sv
// Request/grant bus between the two requesters and the shared register-bank arbiter.
// Handshake: reqN rises with weN/addrN/wdataN stable and stays high until the cycle gntN=1; rdata is valid only while gnt0 or gnt1 is high.
interface regbank_arb_if #(
  parameter int AW = 3
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [15:0]   wdata0;
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [15:0]   wdata1;
  logic          gnt0;
  logic          gnt1;
  logic [15:0]   rdata;
  logic          busy;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  gnt0, gnt1, rdata, busy
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output gnt0, gnt1, rdata, busy
  );
endinterface

// File: rtl/regbank_arb.sv
// Two-requester round-robin arbiter that serialises single read/write accesses
// onto a shared bank of 16-bit registers and returns read data with the grant.
module regbank_arb #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic         clk,
  input  logic         rst,
  regbank_arb_if.slave bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  state_t        state;
  state_t        nxt;
  logic          last;
  logic [15:0]   mem [DEPTH];
  logic          gnt0_r;
  logic          gnt1_r;
  logic          busy_r;
  logic [15:0]   rdata_r;

  logic          go;
  logic          sel;
  logic          we_s;
  logic [AW-1:0] addr_s;
  logic [15:0]   wdata_s;
  logic          in_range;

  // In G0/G1 the granted requester's req is the acknowledge cycle and is ignored.
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) nxt = last ? G0 : G1;
        else if (bus.req0)        nxt = G0;
        else if (bus.req1)        nxt = G1;
        else                      nxt = IDLE;
      end
      G0:      nxt = bus.req1 ? G1 : IDLE;
      G1:      nxt = bus.req0 ? G0 : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    go       = (nxt != IDLE);
    sel      = (nxt == G1);
    we_s     = sel ? bus.we1    : bus.we0;
    addr_s   = sel ? bus.addr1  : bus.addr0;
    wdata_s  = sel ? bus.wdata1 : bus.wdata0;
    in_range = ({1'b0, addr_s} < DEPTH_W);
  end

  // The access happens on the edge entering G0/G1: read-before-write, so a write returns the old contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      busy_r  <= 1'b0;
      rdata_r <= 16'h0000;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'h0000;
    end else begin
      state  <= nxt;
      gnt0_r <= (nxt == G0);
      gnt1_r <= (nxt == G1);
      busy_r <= go;
      if (go) begin
        last    <= sel;
        rdata_r <= in_range ? mem[addr_s] : 16'h0000;
        if (we_s && in_range) mem[addr_s] <= wdata_s;
      end
    end
  end

  assign bus.gnt0  = gnt0_r;
  assign bus.gnt1  = gnt1_r;
  assign bus.busy  = busy_r;
  assign bus.rdata = rdata_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_regbank_arb.sv
// Directed bench for regbank_arb: a per-cycle vector table plus hand-written
// sequences for fairness, reset during a grant and post-reset bank contents.
module tb_regbank_arb;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  regbank_arb_if #(.AW(3)) bus ();

  regbank_arb #(.DEPTH(8), .AW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic        r0;
    logic        w0;
    logic [2:0]  a0;
    logic [15:0] d0;
    logic        r1;
    logic        w1;
    logic [2:0]  a1;
    logic [15:0] d1;
    logic        eg0;
    logic        eg1;
    logic [15:0] erd;
    logic        ebusy;
  } vec_t;

  vec_t vt[21];

  function automatic vec_t mk(logic r0, logic w0, logic [2:0] a0, logic [15:0] d0,
                              logic r1, logic w1, logic [2:0] a1, logic [15:0] d1,
                              logic eg0, logic eg1, logic [15:0] erd, logic ebusy);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.erd = erd; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.req0 = v.r0; bus.we0 = v.w0; bus.addr0 = v.a0; bus.wdata0 = v.d0;
    bus.req1 = v.r1; bus.we1 = v.w1; bus.addr1 = v.a1; bus.wdata1 = v.d1;
  endtask

  task automatic rd0(input logic [2:0] a, input logic [15:0] exp);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = a;
    @(posedge clk); #1;
    chk($sformatf("rd0_gnt_a%0d", a), {15'd0, bus.gnt0}, 16'd1);
    chk($sformatf("rd0_data_a%0d", a), bus.rdata, exp);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    chk($sformatf("rd0_idle_a%0d", a), {15'd0, bus.gnt0}, 16'd0);
  endtask

  // Requester protocol monitor: a req must not fall before its grant.
  logic pend0, pend1;
  always @(negedge clk) begin
    if (!rst) begin
      pend0 = 1'b0;
      pend1 = 1'b0;
    end else begin
      if (pend0 && !bus.req0 && !bus.gnt0) begin
        n_cmp++; n_err++;
        $display("FAIL proto_req0: req0 dropped before gnt0 (t=%0t)", $time);
      end
      if (pend1 && !bus.req1 && !bus.gnt1) begin
        n_cmp++; n_err++;
        $display("FAIL proto_req1: req1 dropped before gnt1 (t=%0t)", $time);
      end
      if (bus.gnt0) pend0 = 1'b0; else if (bus.req0) pend0 = 1'b1;
      if (bus.gnt1) pend1 = 1'b0; else if (bus.req1) pend1 = 1'b1;
    end
  end

  initial begin
    int g0_cnt;
    int g1_cnt;
    int consec;
    logic exp_g1;

    pend0 = 1'b0; pend1 = 1'b0;
    rst = 1'b0;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

    // inputs -> expected outputs after the next rising edge; bank starts cleared, last=1
    vt[0]  = mk(1,0,3'd0,16'h0000, 1,0,3'd1,16'h0000, 1,0,16'h0000,1); // conflict: r0 first
    vt[1]  = mk(1,0,3'd0,16'h0000, 1,0,3'd1,16'h0000, 0,1,16'h0000,1); // r1 next, no gap
    vt[2]  = mk(0,0,3'd0,16'h0000, 1,0,3'd1,16'h0000, 0,0,16'h0000,0);
    vt[3]  = mk(1,1,3'd3,16'hBEEF, 0,0,3'd0,16'h0000, 1,0,16'h0000,1); // write returns old value
    vt[4]  = mk(1,1,3'd3,16'hBEEF, 0,0,3'd0,16'h0000, 0,0,16'h0000,0); // idle gap
    vt[5]  = mk(1,0,3'd3,16'h0000, 0,0,3'd0,16'h0000, 1,0,16'hBEEF,1);
    vt[6]  = mk(1,0,3'd3,16'h0000, 0,0,3'd0,16'h0000, 0,0,16'hBEEF,0);
    vt[7]  = mk(0,0,3'd0,16'h0000, 1,1,3'd7,16'h7777, 0,1,16'h0000,1); // sets last=1
    vt[8]  = mk(0,0,3'd0,16'h0000, 1,1,3'd7,16'h7777, 0,0,16'h0000,0);
    vt[9]  = mk(1,1,3'd5,16'h1111, 1,1,3'd5,16'h2222, 1,0,16'h0000,1); // collision on addr 5
    vt[10] = mk(1,1,3'd5,16'h1111, 1,1,3'd5,16'h2222, 0,1,16'h1111,1);
    vt[11] = mk(0,0,3'd0,16'h0000, 1,1,3'd5,16'h2222, 0,0,16'h1111,0); // rdata holds
    vt[12] = mk(1,0,3'd5,16'h0000, 0,0,3'd0,16'h0000, 1,0,16'h2222,1);
    vt[13] = mk(1,0,3'd5,16'h0000, 0,0,3'd0,16'h0000, 0,0,16'h2222,0);
    vt[14] = mk(0,0,3'd0,16'h0000, 1,0,3'd7,16'h0000, 0,1,16'h7777,1);
    vt[15] = mk(0,0,3'd0,16'h0000, 1,0,3'd7,16'h0000, 0,0,16'h7777,0);
    vt[16] = mk(1,1,3'd2,16'hAAAA, 1,0,3'd3,16'h0000, 1,0,16'h0000,1);
    vt[17] = mk(1,1,3'd2,16'hAAAA, 1,0,3'd3,16'h0000, 0,1,16'hBEEF,1);
    vt[18] = mk(1,0,3'd2,16'h0000, 1,0,3'd3,16'h0000, 1,0,16'hAAAA,1); // r0 re-requests: G1->G0
    vt[19] = mk(1,0,3'd2,16'h0000, 0,0,3'd0,16'h0000, 0,0,16'hAAAA,0);
    vt[20] = mk(0,0,3'd0,16'h0000, 0,0,3'd0,16'h0000, 0,0,16'hAAAA,0);

    #2;
    chk("rst_gnt0",  {15'd0, bus.gnt0}, 16'd0);
    chk("rst_gnt1",  {15'd0, bus.gnt1}, 16'd0);
    chk("rst_busy",  {15'd0, bus.busy}, 16'd0);
    chk("rst_rdata", bus.rdata, 16'h0000);
    chk("rst_state", {14'd0, dbg_state}, 16'd0);
    #20 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) begin
      drive(vt[i]);
      @(posedge clk); #1;
      chk($sformatf("v%0d_gnt0", i),  {15'd0, bus.gnt0}, {15'd0, vt[i].eg0});
      chk($sformatf("v%0d_gnt1", i),  {15'd0, bus.gnt1}, {15'd0, vt[i].eg1});
      chk($sformatf("v%0d_rdata", i), bus.rdata, vt[i].erd);
      chk($sformatf("v%0d_busy", i),  {15'd0, bus.busy}, {15'd0, vt[i].ebusy});
    end

    // fairness: both held, last=0 so requester 1 wins first
    for (int i = 0; i < 10; i++) exp_q.push_back((i % 2 == 0) ? 16'h2222 : 16'hBEEF);
    g0_cnt = 0; g1_cnt = 0; consec = 0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 3'd3;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 3'd5;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      exp_g1 = (i % 2 == 0);
      chk($sformatf("fair%0d_gnt1", i), {15'd0, bus.gnt1}, {15'd0, exp_g1});
      chk($sformatf("fair%0d_gnt0", i), {15'd0, bus.gnt0}, {15'd0, ~exp_g1});
      chk($sformatf("fair%0d_rdata", i), bus.rdata, exp_q.pop_front());
      if (bus.gnt0) g0_cnt++;
      if (bus.gnt1) g1_cnt++;
      if (bus.gnt0 ^ bus.gnt1) consec++;
    end
    bus.req1 = 1'b0;
    chk("fair_g0_count", 16'(g0_cnt), 16'd5);
    chk("fair_g1_count", 16'(g1_cnt), 16'd5);
    chk("fair_consec",   16'(consec), 16'd10);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    chk("fair_end_busy", {15'd0, bus.busy}, 16'd0);

    // reset while in G1 on a write of 0x5A5A to addr 2
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 3'd2; bus.wdata1 = 16'h5A5A;
    @(posedge clk); #1;
    chk("g1rst_gnt1_before", {15'd0, bus.gnt1}, 16'd1);
    chk("g1rst_rdata_old",   bus.rdata, 16'hAAAA);
    #2 rst = 1'b0;
    #1;
    chk("g1rst_gnt1",  {15'd0, bus.gnt1}, 16'd0);
    chk("g1rst_gnt0",  {15'd0, bus.gnt0}, 16'd0);
    chk("g1rst_busy",  {15'd0, bus.busy}, 16'd0);
    chk("g1rst_rdata", bus.rdata, 16'h0000);
    chk("g1rst_state", {14'd0, dbg_state}, 16'd0);
    bus.req1 = 1'b0; bus.we1 = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;

    for (int a = 0; a < 8; a++) rd0(3'(a), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regbank_arb.md
Name: regbank_arb

Overview:
- Two-requester round-robin arbiter and sequencer for a shared bank of 16-bit registers.
- Each requester issues single read or write accesses over a req/gnt handshake.
- The block serialises the accesses, performs them on the shared bank, and returns read data with the grant.
- It sits between the cache-controller side and the tag/status register bank, so both requesters share one storage resource.

Parameters:
- DEPTH, 8, number of 16-bit registers in the bank.
- AW, 3, address width; must equal clog2(DEPTH).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous reset, active-low; block is in reset while rst=0.
- req0  input  1  requester 0 access request; held high until gnt0.
- we0  input  1  requester 0 write enable (1=write, 0=read); valid while req0=1.
- addr0  input  AW  requester 0 register index.
- wdata0  input  16  requester 0 write data.
- req1, we1, addr1, wdata1  input  1/1/AW/16  requester 1 equivalents.
- gnt0  output  1  one-cycle pulse: requester 0 access completed.
- gnt1  output  1  one-cycle pulse: requester 1 access completed.
- rdata  output  16  bank contents read by the granted access; valid while gnt0 or gnt1=1.
- busy  output  1  high while state is not IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, gnt0=gnt1=0, rdata=0, busy=0.
  - All DEPTH registers cleared to 0x0000.
  - Round-robin pointer last=1, so requester 0 wins the first conflict.
- States: IDLE, G0, G1. gnt0 = (state==G0), gnt1 = (state==G1). Outputs are registered; no combinational path from req to gnt.
- Access edge: the access executes on the clock edge that enters G0/G1.
  - Write: reg[addr] <= wdata.
  - rdata <= reg[addr] value before the edge, i.e. read-before-write; a write returns the old contents.
- Latency: req sampled high in IDLE at edge N means gnt asserted in cycle N+1 and rdata valid in the same cycle.
- IDLE transitions:
  - req0 only -> G0.
  - req1 only -> G1.
  - both -> the requester not equal to last.
  - neither -> stay IDLE; rdata holds its value.
- G0 transitions:
  - The granted requester's req is ignored this cycle; it is the acknowledge cycle.
  - Next: req1=1 -> G1, else -> IDLE.
  - last <= 0 on entry to G0.
- G1 transitions: symmetric; req0=1 -> G0, else IDLE; last <= 1 on entry.
- Throughput:
  - Alternating requesters give back-to-back grants, one per cycle.
  - A single requester gets at most one grant every 2 cycles, with an IDLE cycle between.
- Requester protocol:
  - addr/we/wdata must be stable from req rise through the gnt cycle.
  - req may drop, or stay high for a new access, in the cycle after gnt.
  - Dropping req before gnt is illegal; the bench flags it and the block's behaviour is undefined.
- Address: addr >= DEPTH (only possible when DEPTH is not a power of 2) gives a write with no effect and rdata=0x0000.
- Reset mid-access: rst low during G0/G1 aborts immediately.
  - gnt drops asynchronously.
  - Any write already clocked is lost, because the registers clear.
- No starvation: with both reqs held continuously, grants alternate G0, G1, G0, ...

Test Plan:
- Reset: drive rst=0 mid-stream -> gnt0=gnt1=0, busy=0, rdata=0x0000 immediately; after release, a read of every addr returns 0x0000.
- Single write/read: req0 write addr=3 data=0xBEEF, then req0 read addr=3 -> first gnt0 rdata=0x0000 (old value), second gnt0 rdata=0xBEEF; one IDLE cycle between grants.
- Simultaneous first conflict: after reset, req0 and req1 rise in the same cycle (reads addr 0 and 1) -> gnt0 in cycle N+1, gnt1 in cycle N+2, no IDLE gap.
- Fairness: both reqs held for 10 accesses -> strict alternation, 5 grants each, 10 consecutive grant cycles.
- Write collision ordering: req0 writes addr=5 0x1111 and req1 writes addr=5 0x2222 simultaneously, last=1 -> final reg[5]=0x2222; gnt1 rdata=0x1111.
- Reset during G1: assert rst in the cycle gnt1=1 on a write of 0x5A5A to addr=2 -> gnt1 drops asynchronously; a subsequent read of addr=2 returns 0x0000.
